// File: rtl/fofb_pkg.sv
// ---------------------------------------------------------------------------
// fofb_pkg
// Shared definitions for the FOFB readout sequencer:
//   seq_state_t : sequencer state encoding (IDLE/WAIT/SWEEP/FLUSH)
//   park_addr   : readout park address for an index width w (2^w - 2)
//   sat_inc     : saturating increment of a w-bit counter held in 32 bits
// No ports (package).
// ---------------------------------------------------------------------------
package fofb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_FLUSH = 2'd3
    } seq_state_t;

    function automatic logic [31:0] park_addr(input int w);
        return (32'd1 << w) - 32'd2;
    endfunction

    // For w = 32 the shift wraps to 0, so the all-ones limit still comes out right.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fofb_step_timer.sv
// ---------------------------------------------------------------------------
// fofb_step_timer
// Loadable down-counter producing the per-address advance tick of a sweep.
// start_i loads max(cycles_i,1)-1 and latches it as the reload value; the
// counter then reloads itself on every terminal count, so tick_o is high on
// the last clock of each address hold.
// Ports:
//   clk_i    in  : clock
//   rst_i    in  : synchronous active-high reset
//   start_i  in  : load the hold length (sweep start)
//   cycles_i in 4: clocks per address, 0 treated as 1
//   tick_o   out : terminal count, advance the address this cycle
// ---------------------------------------------------------------------------
module fofb_step_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] cycles_i,
    output logic       tick_o
);

    logic [3:0] reload_q, reload_d;
    logic [3:0] count_q, count_d;

    always_comb begin
        reload_d = reload_q;
        count_d  = count_q;
        if (start_i) begin
            reload_d = (cycles_i == 4'd0) ? 4'd0 : cycles_i - 4'd1;
            count_d  = reload_d;
        end else if (count_q == 4'd0) begin
            count_d = reload_q;
        end else begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reload_q <= 4'd0;
            count_q  <= 4'd0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
        end
    end

    assign tick_o = (count_q == 4'd0);

endmodule

// File: rtl/fofb_readout_sequencer.sv
// ---------------------------------------------------------------------------
// fofb_readout_sequencer
// Once per FA cycle waits for the readout to be valid (or to time out), then
// walks fofbDSPreadoutAddress over L BPM slots at stepCycles clocks per slot
// and emits a valid/first/last stream aligned to the one-cycle RAM latency.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing armed, address parked
// WAIT  | FA strobe seen, waiting for readoutValid / readTimeout
// SWEEP | stepping the address over slots 0..L-1
// FLUSH | one cycle at PARK letting the last element's data drain
//
// Build option: FOFB_SEQ_TIMEOUT_SWEEP_EN - when defined a timeout in WAIT
// starts a sweep flagged dspStale; otherwise it counts a miss and returns
// to IDLE, and dspStale is tied low.
//
// Ports:
//   sysClk, sysReset           : clock, synchronous active-high reset
//   FAstrobe                   : arms a new FA cycle
//   readoutValid, readTimeout  : per-cycle readout status levels
//   bpmCount [W:0]             : slots to sweep (clamped, rounded up to even)
//   stepCycles [3:0]           : clocks per slot
//   fofbDSPreadoutAddress [W-1:0], dspValid, dspFirst, dspLast, dspStale
//   sweepActive, sweepDone     : sweep status
//   overrunCount, missCount    : saturating statistics
// ---------------------------------------------------------------------------
module fofb_readout_sequencer
    import fofb_pkg::*;
#(
    parameter int FOFB_INDEX_WIDTH = 9,
    parameter int COUNTER_WIDTH    = 16
) (
    input  logic                        sysClk,
    input  logic                        sysReset,
    input  logic                        FAstrobe,
    input  logic                        readoutValid,
    input  logic                        readTimeout,
    input  logic [FOFB_INDEX_WIDTH:0]   bpmCount,
    input  logic [3:0]                  stepCycles,
    output logic [FOFB_INDEX_WIDTH-1:0] fofbDSPreadoutAddress,
    output logic                        dspValid,
    output logic                        dspFirst,
    output logic                        dspLast,
    output logic                        dspStale,
    output logic                        sweepActive,
    output logic                        sweepDone,
    output logic [COUNTER_WIDTH-1:0]    overrunCount,
    output logic [COUNTER_WIDTH-1:0]    missCount
);

    localparam int W = FOFB_INDEX_WIDTH;
    localparam logic [W-1:0] PARK = W'(park_addr(W));

    seq_state_t state_q, state_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W:0]   last_q, last_d;
    logic pend_q, pend_d;
    logic elem_q, elem_d;          // high in the first cycle an element's address is out
    logic valid_q, valid_d, first_q, first_d, lastf_q, lastf_d;
    logic done_q, done_d, active_q, active_d;
    logic [COUNTER_WIDTH-1:0] over_q, over_d, miss_q, miss_d;
    logic start_sweep, start_stale, tick;
    logic [W:0] len_clamp, len_even;

    fofb_step_timer u_step_timer (
        .clk_i    (sysClk),
        .rst_i    (sysReset),
        .start_i  (start_sweep),
        .cycles_i (stepCycles),
        .tick_o   (tick)
    );

    always_comb begin
        len_clamp = (bpmCount > {1'b0, PARK}) ? {1'b0, PARK} : bpmCount;
        len_even  = len_clamp + {{W{1'b0}}, len_clamp[0]};
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        pend_d      = pend_q;
        elem_d      = 1'b0;
        done_d      = 1'b0;
        over_d      = over_q;
        miss_d      = miss_q;
        start_sweep = 1'b0;
        start_stale = 1'b0;
        valid_d     = elem_q;
        first_d     = elem_q && (addr_q == '0);
        lastf_d     = elem_q && ({1'b0, addr_q} == last_q);

        case (state_q)
            ST_IDLE: begin
                if (FAstrobe) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (FAstrobe) begin
                    over_d = COUNTER_WIDTH'(sat_inc(32'(over_q), COUNTER_WIDTH));
                    miss_d = COUNTER_WIDTH'(sat_inc(32'(miss_q), COUNTER_WIDTH));
                end else if (readoutValid) begin
                    start_sweep = 1'b1;
                end else if (readTimeout) begin
`ifdef FOFB_SEQ_TIMEOUT_SWEEP_EN
                    start_sweep = 1'b1;
                    start_stale = 1'b1;
`else
                    miss_d  = COUNTER_WIDTH'(sat_inc(32'(miss_q), COUNTER_WIDTH));
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_SWEEP: begin
                if (FAstrobe) begin
                    over_d = COUNTER_WIDTH'(sat_inc(32'(over_q), COUNTER_WIDTH));
                    pend_d = 1'b1;
                end
                if (tick) begin
                    if ({1'b0, addr_q} == last_q) begin
                        addr_d  = PARK;
                        state_d = ST_FLUSH;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        elem_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                done_d = 1'b1;
                if (FAstrobe)
                    over_d = COUNTER_WIDTH'(sat_inc(32'(over_q), COUNTER_WIDTH));
                // A strobe that arrived during the sweep re-arms immediately.
                state_d = (FAstrobe || pend_q) ? ST_WAIT : ST_IDLE;
                pend_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_sweep) begin
            last_d = len_even - 1'b1;
            if (len_even == '0) begin
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_SWEEP;
                addr_d  = '0;
                elem_d  = 1'b1;
            end
        end

        active_d = (state_d == ST_SWEEP) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q  <= ST_IDLE;
            addr_q   <= PARK;
            last_q   <= '0;
            pend_q   <= 1'b0;
            elem_q   <= 1'b0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            lastf_q  <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
            over_q   <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            elem_q   <= elem_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            lastf_q  <= lastf_d;
            done_q   <= done_d;
            active_q <= active_d;
            over_q   <= over_d;
            miss_q   <= miss_d;
        end
    end

`ifdef FOFB_SEQ_TIMEOUT_SWEEP_EN
    logic stale_q, stale_d;

    always_comb begin
        stale_d = stale_q;
        if (start_sweep)
            stale_d = start_stale;
        else if (state_q == ST_FLUSH)
            stale_d = 1'b0;
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) stale_q <= 1'b0;
        else          stale_q <= stale_d;
    end

    assign dspStale = stale_q;
`else
    assign dspStale = 1'b0;
`endif

    assign fofbDSPreadoutAddress = addr_q;
    assign dspValid     = valid_q;
    assign dspFirst     = first_q;
    assign dspLast      = lastf_q;
    assign sweepActive  = active_q;
    assign sweepDone    = done_q;
    assign overrunCount = over_q;
    assign missCount    = miss_q;

endmodule

// File: tb/tb_fofb_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fofb_readout_sequencer
// Scoreboard bench for fofb_readout_sequencer at W=5 (PARK=30). Each sweep
// pushes its expected elements (cycle, address, first/last/stale), the PARK
// cycle and the sweepDone cycle; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_fofb_readout_sequencer;

    localparam int W    = 5;
    localparam int CW   = 16;
    localparam int PARK = 30;

    logic          sysClk = 1'b0;
    logic          sysReset = 1'b1;
    logic          FAstrobe = 1'b0;
    logic          readoutValid = 1'b0;
    logic          readTimeout = 1'b0;
    logic [W:0]    bpmCount = '0;
    logic [3:0]    stepCycles = 4'd1;
    logic [W-1:0]  fofbDSPreadoutAddress;
    logic          dspValid, dspFirst, dspLast, dspStale, sweepActive, sweepDone;
    logic [CW-1:0] overrunCount, missCount;

    fofb_readout_sequencer #(
        .FOFB_INDEX_WIDTH (W),
        .COUNTER_WIDTH    (CW)
    ) dut (
        .sysClk                (sysClk),
        .sysReset              (sysReset),
        .FAstrobe              (FAstrobe),
        .readoutValid          (readoutValid),
        .readTimeout           (readTimeout),
        .bpmCount              (bpmCount),
        .stepCycles            (stepCycles),
        .fofbDSPreadoutAddress (fofbDSPreadoutAddress),
        .dspValid              (dspValid),
        .dspFirst              (dspFirst),
        .dspLast               (dspLast),
        .dspStale              (dspStale),
        .sweepActive           (sweepActive),
        .sweepDone             (sweepDone),
        .overrunCount          (overrunCount),
        .missCount             (missCount)
    );

    always #5 sysClk = ~sysClk;

    int cyc = 0;
    always @(posedge sysClk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_over = 0;
    int exp_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int addr;
        bit first;
        bit last;
        bit stale;
    } elem_t;

    elem_t elem_q[$];
    int    done_q[$];
    int    park_q[$];

    task automatic push_sweep(input int v, input int bpm, input int step, input bit stale);
        int l;
        int s;
        elem_t e;
        l = (bpm > PARK) ? PARK : bpm;
        if (l % 2 == 1) l++;
        s = (step == 0) ? 1 : step;
        for (int k = 0; k < l; k++) begin
            e.cyc   = v + 2 + k * s;
            e.addr  = k;
            e.first = (k == 0);
            e.last  = (k == l - 1);
            e.stale = stale;
            elem_q.push_back(e);
        end
        if (l > 0) park_q.push_back(v + 1 + l * s);
        done_q.push_back(v + 2 + l * s);
    endtask

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic fa_pulse();
        FAstrobe = 1'b1;
        step_clk(1);
        FAstrobe = 1'b0;
    endtask

    task automatic pulse_valid(input int bpm, input int step, input bit with_timeout);
        bpmCount   = bpm[W:0];
        stepCycles = step[3:0];
        push_sweep(cyc, bpm, step, 1'b0);
        readoutValid = 1'b1;
        readTimeout  = with_timeout;
        step_clk(1);
        readoutValid = 1'b0;
        readTimeout  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((elem_q.size() + done_q.size() + park_q.size()) != 0 && n < budget) begin
            step_clk(1);
            n++;
        end
        check("sweep_pending_items", elem_q.size() + done_q.size() + park_q.size(), 0);
        elem_q.delete();
        done_q.delete();
        park_q.delete();
    endtask

    task automatic check_counters();
        check("overrun_count", 32'(overrunCount), exp_over);
        check("miss_count", 32'(missCount), exp_miss);
    endtask

    logic [W-1:0] prev_addr = '0;
    elem_t        mon_e;
    int           mon_c;

    always @(negedge sysClk) begin
        if (!sysReset) begin
            if (dspValid) begin
                if (elem_q.size() == 0) begin
                    check("unexpected_dspValid", 1, 0);
                end else begin
                    mon_e = elem_q.pop_front();
                    check("valid_cycle", cyc, mon_e.cyc);
                    check("valid_addr", 32'(prev_addr), mon_e.addr);
                    check("valid_first", 32'(dspFirst), 32'(mon_e.first));
                    check("valid_last", 32'(dspLast), 32'(mon_e.last));
                    check("valid_stale", 32'(dspStale), 32'(mon_e.stale));
                end
            end
            if (sweepDone) begin
                if (done_q.size() == 0) begin
                    check("unexpected_sweepDone", 1, 0);
                end else begin
                    mon_c = done_q.pop_front();
                    check("done_cycle", cyc, mon_c);
                end
            end
            if (park_q.size() != 0 && park_q[0] == cyc) begin
                void'(park_q.pop_front());
                check("park_addr", 32'(fofbDSPreadoutAddress), PARK);
                check("park_bit0_flip", 32'(fofbDSPreadoutAddress[0] ^ prev_addr[0]), 1);
            end
        end
        prev_addr = fofbDSPreadoutAddress;
    end

    initial begin
        step_clk(3);
        check("rst_addr", 32'(fofbDSPreadoutAddress), PARK);
        check("rst_valid", 32'(dspValid), 0);
        check("rst_first", 32'(dspFirst), 0);
        check("rst_last", 32'(dspLast), 0);
        check("rst_stale", 32'(dspStale), 0);
        check("rst_active", 32'(sweepActive), 0);
        check("rst_done", 32'(sweepDone), 0);
        check_counters();
        sysReset = 1'b0;
        step_clk(2);

        // basic sweep, valid 10 cycles after the strobe
        fa_pulse();
        step_clk(9);
        pulse_valid(6, 1, 1'b0);
        check("active_in_sweep", 32'(sweepActive), 1);
        wait_done(100);
        check_counters();

        // odd count, paced by 3
        fa_pulse();
        step_clk(2);
        pulse_valid(5, 3, 1'b0);
        wait_done(100);

        // stepCycles = 0 behaves as 1
        fa_pulse();
        pulse_valid(4, 0, 1'b0);
        wait_done(100);

        // valid and timeout together: normal, not stale
        fa_pulse();
        pulse_valid(6, 2, 1'b1);
        wait_done(100);

        // timeout only
        fa_pulse();
        step_clk(3);
        bpmCount   = 6'd6;
        stepCycles = 4'd1;
`ifdef FOFB_SEQ_TIMEOUT_SWEEP_EN
        push_sweep(cyc, 6, 1, 1'b1);
`else
        exp_miss++;
`endif
        readTimeout = 1'b1;
        step_clk(1);
        readTimeout = 1'b0;
        wait_done(100);
        step_clk(3);
        check("active_after_timeout", 32'(sweepActive), 0);
        check_counters();

        // strobe while waiting, then strobe beating valid in the same cycle
        fa_pulse();
        fa_pulse();
        exp_miss++;
        exp_over++;
        FAstrobe     = 1'b1;
        readoutValid = 1'b1;
        step_clk(1);
        FAstrobe     = 1'b0;
        readoutValid = 1'b0;
        exp_miss++;
        exp_over++;
        step_clk(2);
        check("no_sweep_on_fa_priority", 32'(sweepActive), 0);
        check_counters();
        pulse_valid(2, 1, 1'b0);
        wait_done(100);

        // overrun at element 2: sweep completes, re-arms straight into WAIT
        fa_pulse();
        pulse_valid(8, 1, 1'b0);
        step_clk(2);
        FAstrobe = 1'b1;
        step_clk(1);
        FAstrobe = 1'b0;
        exp_over++;
        wait_done(100);
        step_clk(3);
        check("idle_after_overrun", 32'(sweepActive), 0);
        check_counters();
        pulse_valid(4, 2, 1'b0);
        wait_done(100);

        // clamp to 30 elements, then empty sweep
        fa_pulse();
        pulse_valid(40, 1, 1'b0);
        wait_done(200);
        fa_pulse();
        pulse_valid(0, 1, 1'b0);
        wait_done(50);
        check_counters();

        // reset at element 3
        fa_pulse();
        pulse_valid(8, 1, 1'b0);
        step_clk(3);
        sysReset = 1'b1;
        elem_q.delete();
        done_q.delete();
        park_q.delete();
        exp_over = 0;
        exp_miss = 0;
        step_clk(1);
        sysReset = 1'b0;
        check("midrst_addr", 32'(fofbDSPreadoutAddress), PARK);
        check("midrst_valid", 32'(dspValid), 0);
        check("midrst_first", 32'(dspFirst), 0);
        check("midrst_last", 32'(dspLast), 0);
        check("midrst_done", 32'(sweepDone), 0);
        check("midrst_active", 32'(sweepActive), 0);
        check_counters();
        step_clk(20);
        check("post_rst_addr", 32'(fofbDSPreadoutAddress), PARK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fofb_readout_sequencer.md
# fofb_readout_sequencer

Sweeps the fast-orbit-feedback DSP readout port once per FA cycle. It waits for the per-cycle readout to become valid, or to time out, then walks `fofbDSPreadoutAddress` over every BPM slot at a programmable pace. It emits a data-aligned valid/first/last stream to the correction DSP. It sits in the `sysClk` domain between the link-gathering logic and the FOFB DSP, and also reports sweep statistics to the MicroBlaze.

## Interface
- `FOFB_INDEX_WIDTH`, 9: readout address width; park address PARK = 2^W−2.
- `COUNTER_WIDTH`, 16: width of the statistics counters.
- `sysClk` in 1: system clock.
- `sysReset` in 1: synchronous, active-high reset.
- `FAstrobe` in 1: one-cycle fast-acquisition strobe; arms a new cycle.
- `readoutValid` in 1: level; all cells were received this cycle.
- `readTimeout` in 1: level; the readout timed out this cycle.
- `bpmCount` in W+1: number of BPM slots to sweep; sampled at sweep start.
- `stepCycles` in 4: clocks each address is held; 0 is treated as 1; sampled at sweep start.
- `fofbDSPreadoutAddress` out W: readout address.
- `dspValid` out 1: readout data for the current element is on the DSP bus this cycle.
- `dspFirst` out 1: qualifies `dspValid`; first element of the sweep.
- `dspLast` out 1: qualifies `dspValid`; last element of the sweep.
- `dspStale` out 1: level; the current sweep was started by a timeout.
- `sweepActive` out 1: level; state is SWEEP or FLUSH.
- `sweepDone` out 1: one-cycle strobe at sweep completion.
- `overrunCount` out COUNTER_WIDTH: saturating count of FAstrobes that arrived during WAIT, SWEEP or FLUSH.
- `missCount` out COUNTER_WIDTH: saturating count of FA cycles that produced no sweep.

## Operation
**States:** IDLE, WAIT, SWEEP, FLUSH.
- IDLE → WAIT on `FAstrobe`.
- WAIT → SWEEP when `readoutValid` is high.
- WAIT on `readTimeout`: see Configuration.
- WAIT on a new `FAstrobe`: increment `missCount` and `overrunCount`, stay in WAIT.
- SWEEP:
  - Address starts at 0 and increments by 1 after each hold of max(stepCycles,1) clocks.
  - After element L−1 has been held, the address moves to PARK and the state goes to FLUSH.
- FLUSH lasts exactly one cycle, then returns to IDLE with `sweepDone`=1.

**Effective length:**
- L = min(bpmCount, 2^W−2), then rounded up to even.
- Because L is even, the last element is odd and PARK is even. Every address change inside a sweep and the exit to PARK therefore flips bit 0. Entry from PARK to 0 does not.
- L=0: SWEEP is skipped; WAIT goes straight to FLUSH. `sweepDone` still fires, and `dspValid` never asserts.

**Data alignment:**
- `dspValid` pulses once per element, one clock after that element's address first appears. This matches the single-cycle readout RAM latency.
- `dspFirst` and `dspLast` mark elements 0 and L−1.

**FAstrobe during a sweep:**
- SWEEP or FLUSH: increment `overrunCount`, set a pending flag, and let the sweep finish.
- On return to IDLE with the flag set, go directly to WAIT and clear the flag.

**Simultaneous events:**
- `FAstrobe` has priority over `readoutValid`/`readTimeout` in the same cycle; the state stays in WAIT.
- `readoutValid` and `readTimeout` both high: treated as valid, `dspStale`=0.

**Counters** saturate at all-ones.

**Reset:**
- State IDLE; address PARK.
- `dspValid`, `dspFirst`, `dspLast`, `dspStale`, `sweepActive`, `sweepDone` all 0.
- Counters 0; pending flag 0.
- Reset mid-sweep aborts the sweep immediately, with no `sweepDone`.

## Timing
- `FAstrobe` at cycle t puts the state in WAIT at t+1.
- `readoutValid` sampled high at cycle v: address 0 at v+1, first `dspValid` at v+2.
- Element k's address appears at v+1+k·S, where S = max(stepCycles,1).
- Last `dspValid` at v+2+(L−1)·S.
- PARK appears at v+1+L·S; `sweepDone` at v+2+L·S.
- All outputs are registered.

## Configuration
Macro: `FOFB_SEQ_TIMEOUT_SWEEP_EN`.
- **Defined:** `readTimeout` in WAIT starts a normal sweep with `dspStale`=1 for its whole duration. Downstream uses its saved previous values.
- **Undefined:** `readTimeout` in WAIT increments `missCount` and returns to IDLE with no sweep and no `sweepDone`. `dspStale` is tied to 0.

## Structure
- Shared package `fofb_pkg` holds:
  - the state enum (IDLE/WAIT/SWEEP/FLUSH);
  - the PARK address function of W;
  - the saturating-increment function used by both counters.
- One sub-module, `fofb_step_timer`: a loadable down-counter that produces the per-address advance tick from `stepCycles`.

## Test plan
1. **Basic sweep.** W=5, bpmCount=6, stepCycles=1; FAstrobe, then readoutValid 10 cycles later → address sequence 0..5 then 30; six `dspValid` pulses; `dspFirst` on the first, `dspLast` on the sixth; one `sweepDone`.
2. **Odd count, paced.** bpmCount=5, stepCycles=3 → L=6; each address held 3 clocks; `dspValid` spacing 3; `sweepDone` at v+20.
3. **Timeout.**
   - Macro defined: readTimeout only → sweep runs with `dspStale`=1.
   - Macro undefined: `missCount`=1, no `dspValid`.
4. **Overrun.** FAstrobe at element 2 of a sweep with bpmCount=8 → sweep completes all 8 elements, `overrunCount`=1, state goes straight to WAIT after `sweepDone`.
5. **Boundaries.**
   - bpmCount=40 with W=5 → clamped to 30 elements; exit to PARK flips address bit 0.
   - bpmCount=0 → `sweepDone` only, no `dspValid`.
6. **Reset mid-sweep.** `sysReset` at element 3 → next cycle: address 30, all strobes 0, counters 0, no `sweepDone`.
